// File: rtl/regfile_mp.sv
// Multi-port integer register file: NUM_RD async read ports, two prioritised sync write ports,
// optional write->read bypass, a per-register pending scoreboard and a sequential clear sweep.
module regfile_mp #(
    parameter int  XLEN     = 32,
    parameter int  NUM_REGS = 32,
    parameter int  NUM_RD   = 2,
    parameter int  BYPASS   = 1,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_RD*AW-1:0]   rd_addr_i,
    output logic [NUM_RD*XLEN-1:0] rd_data_o,
    input  logic [AW-1:0]          dbg_addr_i,
    output logic [XLEN-1:0]        dbg_data_o,
    input  logic [1:0]             wr_en_i,
    input  logic [2*AW-1:0]        wr_addr_i,
    input  logic [2*XLEN-1:0]      wr_data_i,
    input  logic                   rsv_en_i,
    input  logic [AW-1:0]          rsv_addr_i,
    output logic [NUM_REGS-1:0]    pend_o,
    input  logic                   clear_req_i,
    output logic                   clear_busy_o,
    output logic                   clear_done_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SWEEP,
        ST_DONE
    } state_t;

    localparam logic [AW-1:0] IDX_FIRST = AW'(1);
    localparam logic [AW-1:0] IDX_LAST  = AW'(NUM_REGS - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [AW-1:0]       r_idx;
    logic [AW-1:0]       w_idx_nxt;
    logic [XLEN-1:0]     r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_pend;
    logic [NUM_REGS-1:0] w_pend_nxt;

    logic [AW-1:0]       w_wa0;
    logic [AW-1:0]       w_wa1;
    logic [XLEN-1:0]     w_wd0;
    logic [XLEN-1:0]     w_wd1;
    logic                w_we0;
    logic                w_we1;
    logic                w_rsv;
    logic                w_sweep_start;

    assign w_wa0 = wr_addr_i[0 +: AW];
    assign w_wa1 = wr_addr_i[AW +: AW];
    assign w_wd0 = wr_data_i[0 +: XLEN];
    assign w_wd1 = wr_data_i[XLEN +: XLEN];

    // Writes land in IDLE and DONE; reserves and sweep requests only in IDLE.
    assign w_we0         = wr_en_i[0] && (w_wa0 != '0) && (r_state != ST_SWEEP);
    assign w_we1         = wr_en_i[1] && (w_wa1 != '0) && (r_state != ST_SWEEP);
    assign w_rsv         = rsv_en_i && (rsv_addr_i != '0) && (r_state == ST_IDLE);
    assign w_sweep_start = clear_req_i && (r_state == ST_IDLE);

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // NOTE: defaults first, so no branch leaves an output unassigned and infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        unique case (r_state)
            ST_IDLE: begin
                if (clear_req_i) begin
                    w_state_nxt = ST_SWEEP;
                    w_idx_nxt   = IDX_FIRST;
                end
            end
            ST_SWEEP: begin
                w_idx_nxt = r_idx + IDX_FIRST;
                if (r_idx == IDX_LAST) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // A reserve applied after the write clears lets a new producer keep the bit set.
    always_comb begin
        w_pend_nxt = r_pend;
        if (w_we0) begin
            w_pend_nxt[w_wa0] = 1'b0;
        end
        if (w_we1) begin
            w_pend_nxt[w_wa1] = 1'b0;
        end
        if (w_rsv) begin
            w_pend_nxt[rsv_addr_i] = 1'b1;
        end
        if (w_sweep_start) begin
            w_pend_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_nxt;
        end
    end

    // NOTE: the storage array is reset element by element because reset must leave every register zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (r_state == ST_SWEEP) begin
            r_regs[r_idx] <= '0;
        end else begin
            if (w_we0) begin
                r_regs[w_wa0] <= w_wd0;
            end
            if (w_we1) begin
                r_regs[w_wa1] <= w_wd1;
            end
        end
    end

    // Read ports: port 1 is checked last so it wins the bypass when both writes hit.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0]   w_ra;
        logic [XLEN-1:0] w_val;

        assign w_ra = rd_addr_i[k*AW +: AW];

        always_comb begin
            w_val = r_regs[w_ra];
            if (BYPASS != 0) begin
                if (w_we0 && (w_wa0 == w_ra)) begin
                    w_val = w_wd0;
                end
                if (w_we1 && (w_wa1 == w_ra)) begin
                    w_val = w_wd1;
                end
            end
            if (w_ra == '0) begin
                w_val = '0;
            end
        end

        assign rd_data_o[k*XLEN +: XLEN] = w_val;
    end

    assign dbg_data_o   = r_regs[dbg_addr_i];
    assign pend_o       = r_pend;
    assign clear_busy_o = (r_state == ST_SWEEP);
    assign clear_done_o = (r_state == ST_DONE);

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural array/scoreboard model.
module tb_regfile_mp;

    localparam int XLEN     = 32;
    localparam int NUM_REGS = 32;
    localparam int NUM_RD   = 2;
    localparam int BYPASS   = 1;
    localparam int AW       = $clog2(NUM_REGS);

    logic                   clk;
    logic                   rst;
    logic [NUM_RD*AW-1:0]   rd_addr_i;
    logic [NUM_RD*XLEN-1:0] rd_data_o;
    logic [AW-1:0]          dbg_addr_i;
    logic [XLEN-1:0]        dbg_data_o;
    logic [1:0]             wr_en_i;
    logic [2*AW-1:0]        wr_addr_i;
    logic [2*XLEN-1:0]      wr_data_i;
    logic                   rsv_en_i;
    logic [AW-1:0]          rsv_addr_i;
    logic [NUM_REGS-1:0]    pend_o;
    logic                   clear_req_i;
    logic                   clear_busy_o;
    logic                   clear_done_o;

    regfile_mp #(
        .XLEN    (XLEN),
        .NUM_REGS(NUM_REGS),
        .NUM_RD  (NUM_RD),
        .BYPASS  (BYPASS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_addr_i   (rd_addr_i),
        .rd_data_o   (rd_data_o),
        .dbg_addr_i  (dbg_addr_i),
        .dbg_data_o  (dbg_data_o),
        .wr_en_i     (wr_en_i),
        .wr_addr_i   (wr_addr_i),
        .wr_data_i   (wr_data_i),
        .rsv_en_i    (rsv_en_i),
        .rsv_addr_i  (rsv_addr_i),
        .pend_o      (pend_o),
        .clear_req_i (clear_req_i),
        .clear_busy_o(clear_busy_o),
        .clear_done_o(clear_done_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "time limit");
    end

    int checks = 0;
    int errors = 0;

    // Behavioural model: plain array, pending bitmap, and a sweep position counter.
    logic [XLEN-1:0]     m_regs [NUM_REGS];
    logic [NUM_REGS-1:0] m_pend;
    logic                m_busy;
    logic                m_done;
    int                  m_pos;
    logic                obs_busy;
    logic                obs_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] exp_read(input logic [AW-1:0] a);
        logic [XLEN-1:0] v;
        v = m_regs[a];
        if (!m_busy) begin
            for (int p = 0; p < 2; p++) begin
                if (wr_en_i[p] && (wr_addr_i[p*AW +: AW] == a)) begin
                    v = wr_data_i[p*XLEN +: XLEN];
                end
            end
        end
        if (a == '0) begin
            v = '0;
        end
        return v;
    endfunction

    task automatic model_update();
        logic          was_done;
        logic [AW-1:0] a;
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                m_regs[i] = '0;
            end
            m_pend = '0;
            m_busy = 1'b0;
            m_done = 1'b0;
            m_pos  = 0;
        end else if (m_busy) begin
            m_regs[m_pos] = '0;
            if (m_pos == NUM_REGS - 1) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end else begin
                m_pos++;
            end
        end else begin
            was_done = m_done;
            m_done   = 1'b0;
            for (int p = 0; p < 2; p++) begin
                a = wr_addr_i[p*AW +: AW];
                if (wr_en_i[p] && (a != '0)) begin
                    m_regs[a] = wr_data_i[p*XLEN +: XLEN];
                    m_pend[a] = 1'b0;
                end
            end
            if (!was_done && rsv_en_i && (rsv_addr_i != '0)) begin
                m_pend[rsv_addr_i] = 1'b1;
            end
            if (!was_done && clear_req_i) begin
                m_pend = '0;
                m_busy = 1'b1;
                m_pos  = 1;
            end
        end
    endtask

    // One clock: compare every output at the falling edge, then advance the model at the rising edge.
    task automatic cycle();
        @(negedge clk);
        for (int k = 0; k < NUM_RD; k++) begin
            check($sformatf("rd%0d", k), rd_data_o[k*XLEN +: XLEN], exp_read(rd_addr_i[k*AW +: AW]));
        end
        check("dbg", dbg_data_o, m_regs[dbg_addr_i]);
        check("pend", pend_o, m_pend);
        check("busy", 32'(clear_busy_o), 32'(m_busy));
        check("done", 32'(clear_done_o), 32'(m_done));
        obs_busy = clear_busy_o;
        obs_done = clear_done_o;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive_idle();
        wr_en_i     = '0;
        rsv_en_i    = 1'b0;
        clear_req_i = 1'b0;
        rst         = 1'b0;
    endtask

    task automatic wr(input int p, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        wr_en_i[p]                = 1'b1;
        wr_addr_i[p*AW +: AW]     = a;
        wr_data_i[p*XLEN +: XLEN] = d;
    endtask

    task automatic set_rd(input int k, input logic [AW-1:0] a);
        rd_addr_i[k*AW +: AW] = a;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 3) == 0) begin
            return AW'($urandom_range(0, 3));
        end
        return AW'($urandom_range(0, NUM_REGS - 1));
    endfunction

    initial begin
        int busy_cnt;
        int done_cnt;
        int sel;

        rd_addr_i  = '0;
        dbg_addr_i = '0;
        wr_addr_i  = '0;
        wr_data_i  = '0;
        rsv_addr_i = '0;
        drive_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        model_update();
        #1;
        rst = 1'b0;
        #1;
        check("rst_rd0", rd_data_o[0 +: XLEN], 32'h0);
        check("rst_rd1", rd_data_o[XLEN +: XLEN], 32'h0);
        check("rst_dbg", dbg_data_o, 32'h0);
        check("rst_pend", pend_o, 32'h0);
        check("rst_busy", 32'(clear_busy_o), 32'h0);

        // x0 is hardwired to zero.
        wr(0, AW'(0), 32'hDEAD_BEEF);
        cycle();
        drive_idle();
        #1;
        check("x0_read", rd_data_o[0 +: XLEN], 32'h0);
        check("x0_dbg", dbg_data_o, 32'h0);

        // Same-address dual write: port 1 wins; bypass shows it, debug port does not.
        wr(0, AW'(5), 32'h11);
        wr(1, AW'(5), 32'h22);
        set_rd(0, AW'(5));
        dbg_addr_i = AW'(5);
        #1;
        check("bypass_rd0", rd_data_o[0 +: XLEN], 32'h22);
        check("bypass_dbg_old", dbg_data_o, 32'h0);
        cycle();
        drive_idle();
        #1;
        check("x5_after", dbg_data_o, 32'h22);
        check("x5_rd0_after", rd_data_o[0 +: XLEN], 32'h22);

        // Pending scoreboard: reserve, writeback clears, reserve+write keeps it set.
        rsv_en_i   = 1'b1;
        rsv_addr_i = AW'(7);
        cycle();
        drive_idle();
        #1;
        check("pend7_rsv", 32'(pend_o[7]), 32'h1);
        wr(0, AW'(7), 32'h44);
        cycle();
        drive_idle();
        #1;
        check("pend7_wb", 32'(pend_o[7]), 32'h0);
        rsv_en_i   = 1'b1;
        rsv_addr_i = AW'(7);
        wr(1, AW'(7), 32'h55);
        cycle();
        drive_idle();
        dbg_addr_i = AW'(7);
        #1;
        check("pend7_rsv_wr", 32'(pend_o[7]), 32'h1);
        check("x7_rsv_wr", dbg_data_o, 32'h55);

        // Full sweep with ignored writes, reserves and a second request partway through.
        for (int i = 1; i < NUM_REGS; i++) begin
            wr(0, AW'(i), 32'(i));
            cycle();
            drive_idle();
        end
        rsv_en_i   = 1'b1;
        rsv_addr_i = AW'(9);
        cycle();
        drive_idle();
        #1;
        check("pend9_pre_sweep", 32'(pend_o[9]), 32'h1);
        clear_req_i = 1'b1;
        cycle();
        drive_idle();
        busy_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (i == 5) begin
                wr(0, AW'(3), 32'hAB);
                rsv_en_i    = 1'b1;
                rsv_addr_i  = AW'(4);
                clear_req_i = 1'b1;
                set_rd(1, AW'(3));
            end
            cycle();
            drive_idle();
            if (obs_busy) busy_cnt++;
            if (obs_done) done_cnt++;
        end
        check("sweep_busy_cycles", 32'(busy_cnt), 32'd31);
        check("sweep_done_pulses", 32'(done_cnt), 32'd1);
        check("sweep_pend_clear", pend_o, 32'h0);
        for (int a = 0; a < NUM_REGS; a++) begin
            dbg_addr_i = AW'(a);
            set_rd(0, AW'(a));
            cycle();
            check($sformatf("swept_x%0d", a), dbg_data_o, 32'h0);
        end

        // Reset during the tenth sweep cycle aborts the sweep and zeroes everything.
        for (int i = 1; i < NUM_REGS; i++) begin
            wr(1, AW'(i), 32'h100 + 32'(i));
            cycle();
            drive_idle();
        end
        clear_req_i = 1'b1;
        cycle();
        drive_idle();
        repeat (9) cycle();
        rst = 1'b1;
        cycle();
        drive_idle();
        #1;
        check("rst_sweep_busy", 32'(clear_busy_o), 32'h0);
        check("rst_sweep_done", 32'(clear_done_o), 32'h0);
        for (int a = 0; a < NUM_REGS; a++) begin
            dbg_addr_i = AW'(a);
            cycle();
            check($sformatf("rst_sweep_x%0d", a), dbg_data_o, 32'h0);
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            rst         = ($urandom_range(0, 299) == 0);
            clear_req_i = ($urandom_range(0, 99) == 0);
            wr_en_i     = 2'($urandom_range(0, 3));
            for (int p = 0; p < 2; p++) begin
                wr_addr_i[p*AW +: AW]     = rand_addr();
                wr_data_i[p*XLEN +: XLEN] = $urandom;
            end
            rsv_en_i   = ($urandom_range(0, 3) == 0);
            rsv_addr_i = rand_addr();
            for (int k = 0; k < NUM_RD; k++) begin
                if ($urandom_range(0, 1) == 1) begin
                    sel = int'($urandom_range(0, 1));
                    set_rd(k, wr_addr_i[sel*AW +: AW]);
                end else begin
                    set_rd(k, rand_addr());
                end
            end
            dbg_addr_i = rand_addr();
            cycle();
        end
        drive_idle();
        repeat (4) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
